// File: rtl/mem_port_arbiter.sv
// Arbiter sharing BRAM port B between the CPU LSU and the UART debug
// memory-access controller, with a debug lock and a CPU starvation guard.
//
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_gnt      CPU request, combinational grant
//   cpu_rvalid, cpu_rdata                 CPU read return
//   dbg_req/lock/we/addr/wdata -> dbg_gnt debug request, lock, grant
//   dbg_rvalid, dbg_rdata                 debug read return
//   mem_addr/we/din, mem_dout             BRAM port B
// Optional: define MEM_ARB_PERF_CNT_EN to add cpu_stall_cnt and
// dbg_grant_cnt saturating performance counters.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 32,
   parameter int RD_LATENCY   = 1,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cpu_req,
   input  logic [DATA_WIDTH/8-1:0] cpu_we,
   input  logic [ADDR_WIDTH-1:0]   cpu_addr,
   input  logic [DATA_WIDTH-1:0]   cpu_wdata,
   output logic                    cpu_gnt,
   output logic                    cpu_rvalid,
   output logic [DATA_WIDTH-1:0]   cpu_rdata,
   input  logic                    dbg_req,
   input  logic                    dbg_lock,
   input  logic [DATA_WIDTH/8-1:0] dbg_we,
   input  logic [ADDR_WIDTH-1:0]   dbg_addr,
   input  logic [DATA_WIDTH-1:0]   dbg_wdata,
   output logic                    dbg_gnt,
   output logic                    dbg_rvalid,
   output logic [DATA_WIDTH-1:0]   dbg_rdata,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH/8-1:0] mem_we,
   output logic [DATA_WIDTH-1:0]   mem_din,
   input  logic [DATA_WIDTH-1:0]   mem_dout
`ifdef MEM_ARB_PERF_CNT_EN
  ,output logic [31:0]             cpu_stall_cnt,
   output logic [31:0]             dbg_grant_cnt
`endif
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, SHARED, LOCKED, FORCE_CPU} state_t;

   state_t                  state_q, state_d;
   logic                    last_dbg_q;
   logic [CNT_W-1:0]        starve_q, starve_d, starve_inc;
   logic                    arb;
   logic                    rd_gnt;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   din_q;
   logic [RD_LATENCY-1:0]   tag_v, tag_dbg;

   assign starve_inc = (starve_q == CNT_MAX) ? starve_q : starve_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      cpu_gnt  = 1'b0;
      dbg_gnt  = 1'b0;
      arb      = 1'b0;
      unique case (state_q)
         FORCE_CPU: begin
            cpu_gnt  = cpu_req;
            starve_d = '0;
            state_d  = LOCKED;
         end
         LOCKED: begin
            if (dbg_lock) begin
               dbg_gnt = dbg_req;
               if (cpu_req) begin
                  starve_d = starve_inc;
                  if (starve_inc == CNT_LIM)
                     state_d = FORCE_CPU;
               end else begin
                  starve_d = '0;
               end
            end else begin
               // lock released: unlocked arbitration applies this cycle
               arb = 1'b1;
            end
         end
         default: arb = 1'b1;
      endcase
      if (arb) begin
         starve_d = '0;
         if (cpu_req && dbg_req) begin
            cpu_gnt = last_dbg_q;
            dbg_gnt = ~last_dbg_q;
         end else begin
            cpu_gnt = cpu_req;
            dbg_gnt = dbg_req;
         end
         if (dbg_gnt && dbg_lock)
            state_d = LOCKED;
         else if (cpu_req || dbg_req)
            state_d = SHARED;
         else
            state_d = IDLE;
      end
      if (rst) begin
         cpu_gnt = 1'b0;
         dbg_gnt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         starve_q   <= '0;
         last_dbg_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         if (cpu_gnt)
            last_dbg_q <= 1'b0;
         else if (dbg_gnt)
            last_dbg_q <= 1'b1;
      end
   end

   // Idle cycles keep the last address/data on the port to avoid toggling.
   always_comb begin
      mem_we   = '0;
      mem_addr = addr_q;
      mem_din  = din_q;
      if (cpu_gnt) begin
         mem_we   = cpu_we;
         mem_addr = cpu_addr;
         mem_din  = cpu_wdata;
      end else if (dbg_gnt) begin
         mem_we   = dbg_we;
         mem_addr = dbg_addr;
         mem_din  = dbg_wdata;
      end
   end

   assign rd_gnt = (cpu_gnt && cpu_we == '0) || (dbg_gnt && dbg_we == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         din_q   <= '0;
         tag_v   <= '0;
         tag_dbg <= '0;
      end else begin
         addr_q     <= mem_addr;
         din_q      <= mem_din;
         tag_v[0]   <= rd_gnt;
         tag_dbg[0] <= dbg_gnt;
         for (int i = 1; i < RD_LATENCY; i++) begin
            tag_v[i]   <= tag_v[i-1];
            tag_dbg[i] <= tag_dbg[i-1];
         end
      end
   end

   assign cpu_rvalid = tag_v[RD_LATENCY-1] & ~tag_dbg[RD_LATENCY-1];
   assign dbg_rvalid = tag_v[RD_LATENCY-1] &  tag_dbg[RD_LATENCY-1];
   assign cpu_rdata  = rst ? '0 : mem_dout;
   assign dbg_rdata  = rst ? '0 : mem_dout;

`ifdef MEM_ARB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_stall_cnt <= '0;
         dbg_grant_cnt <= '0;
      end else begin
         if (cpu_req && !cpu_gnt && cpu_stall_cnt != 32'hFFFF_FFFF)
            cpu_stall_cnt <= cpu_stall_cnt + 32'd1;
         if (dbg_gnt && dbg_grant_cnt != 32'hFFFF_FFFF)
            dbg_grant_cnt <= dbg_grant_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: random requesters, behavioural BRAM,
// grant/port checks per cycle and a read-return scoreboard.
module tb_mem_port_arbiter;
   localparam int AW = 16, DW = 32, BW = 4, LAT = 1, LIMIT = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cpu_req = 0, dbg_req = 0, dbg_lock = 0;
   logic [BW-1:0] cpu_we = 0, dbg_we = 0;
   logic [AW-1:0] cpu_addr = 0, dbg_addr = 0;
   logic [DW-1:0] cpu_wdata = 0, dbg_wdata = 0;
   logic cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic [DW-1:0] cpu_rdata, dbg_rdata, mem_din, mem_dout;
   logic [AW-1:0] mem_addr;
   logic [BW-1:0] mem_we;
`ifdef MEM_ARB_PERF_CNT_EN
   logic [31:0] cpu_stall_cnt, dbg_grant_cnt;
`endif

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .RD_LATENCY(LAT), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
      .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_lock(dbg_lock), .dbg_we(dbg_we),
      .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
      .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
      .mem_dout(mem_dout)
`ifdef MEM_ARB_PERF_CNT_EN
     ,.cpu_stall_cnt(cpu_stall_cnt), .dbg_grant_cnt(dbg_grant_cnt)
`endif
   );

   function automatic logic [DW-1:0] init_word(input int i);
      return (i == 4) ? 32'hDEAD_BEEF : 32'h0101_0101 * i;
   endfunction

   // behavioural BRAM, contents reinitialised by rst
   logic [DW-1:0] bram [16];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) bram[i] <= init_word(i);
      end else begin
         for (int b = 0; b < BW; b++)
            if (mem_we[b]) bram[mem_addr[5:2]][b*8 +: 8] <= mem_din[b*8 +: 8];
      end
      mem_dout <= bram[mem_addr[5:2]];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_fail = 0;

   typedef struct { int due; logic [DW-1:0] data; } exp_t;
   exp_t cq[$], dq[$];

   // reference model state
   logic [DW-1:0] model_mem [16];
   bit m_locked, m_force, m_last_dbg;
   int m_starve;
   logic [AW-1:0] la;
   logic [DW-1:0] ld;

   // pending requester transactions
   bit c_pend = 0, d_pend = 0;
   logic [BW-1:0] c_we, d_we;
   logic [AW-1:0] c_addr, d_addr;
   logic [DW-1:0] c_wd, d_wd;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_locked = 0; m_force = 0; m_starve = 0; m_last_dbg = 1;
      la = '0; ld = '0;
      for (int i = 0; i < 16; i++) model_mem[i] = init_word(i);
      cq.delete(); dq.delete();
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (cpu_rvalid) begin
         n_chk++;
         if (cq.size() == 0) begin
            n_fail++;
            $display("FAIL cpu_rvalid unexpected @cyc %0d", cyc);
         end else begin
            e = cq.pop_front();
            if (cpu_rdata !== e.data || cyc != e.due) begin
               n_fail++;
               $display("FAIL cpu_rdata @cyc %0d: got %h expected %h due %0d",
                        cyc, cpu_rdata, e.data, e.due);
            end
         end
      end else if (cq.size() != 0 && cq[0].due <= cyc) begin
         n_chk++; n_fail++;
         $display("FAIL cpu_rvalid missing @cyc %0d: got 0 expected 1", cyc);
         void'(cq.pop_front());
      end
      if (dbg_rvalid) begin
         n_chk++;
         if (dq.size() == 0) begin
            n_fail++;
            $display("FAIL dbg_rvalid unexpected @cyc %0d", cyc);
         end else begin
            e = dq.pop_front();
            if (dbg_rdata !== e.data || cyc != e.due) begin
               n_fail++;
               $display("FAIL dbg_rdata @cyc %0d: got %h expected %h due %0d",
                        cyc, dbg_rdata, e.data, e.due);
            end
         end
      end else if (dq.size() != 0 && dq[0].due <= cyc) begin
         n_chk++; n_fail++;
         $display("FAIL dbg_rvalid missing @cyc %0d: got 0 expected 1", cyc);
         void'(dq.pop_front());
      end
   end

   task automatic gen(input bit rd_only, output logic [BW-1:0] we,
                      output logic [AW-1:0] a, output logic [DW-1:0] wd);
      we = (rd_only || $urandom_range(1) == 0) ? '0 : BW'($urandom_range(1, 15));
      a  = 16'($urandom) & 16'hFFFC;
      wd = $urandom;
   endtask

   task automatic step(input int cr, input int dr, input int lk,
                       input bit rd_only, input bit rst_mid = 0);
      bit pc, pd;
      logic [BW-1:0] we;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      exp_t e;
      @(negedge clk);
      if (!c_pend && $urandom_range(99) < cr) begin
         gen(rd_only, c_we, c_addr, c_wd); c_pend = 1;
      end
      if (!d_pend && $urandom_range(99) < dr) begin
         gen(rd_only, d_we, d_addr, d_wd); d_pend = 1;
      end
      if (lk == 0) dbg_lock = 0;
      else if (lk == 1) dbg_lock = 1;
      else if ($urandom_range(9) == 0) dbg_lock = ~dbg_lock;
      cpu_req = c_pend; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
      dbg_req = d_pend; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wd;
      #1;
      // who should own the port this cycle
      if (m_force) begin pc = c_pend; pd = 0; end
      else if (m_locked && dbg_lock) begin pc = 0; pd = d_pend; end
      else if (c_pend && d_pend) begin pc = m_last_dbg; pd = !m_last_dbg; end
      else begin pc = c_pend; pd = d_pend; end
      chk("grant", {62'd0, cpu_gnt, dbg_gnt}, {62'd0, pc, pd});
      if (pc || pd) begin
         we = pc ? c_we : d_we;
         a  = pc ? c_addr : d_addr;
         wd = pc ? c_wd : d_wd;
         chk("mem_drive", {mem_we, mem_addr, mem_din}, {we, a, wd});
         if (we == '0) begin
            e.due = cyc + LAT;
            e.data = model_mem[a[5:2]];
            if (pc) cq.push_back(e); else dq.push_back(e);
         end else begin
            for (int b = 0; b < BW; b++)
               if (we[b]) model_mem[a[5:2]][b*8 +: 8] = wd[b*8 +: 8];
         end
         la = a; ld = wd;
         if (pc) c_pend = 0; else d_pend = 0;
      end else begin
         chk("mem_idle", {mem_we, mem_addr, mem_din}, {4'h0, la, ld});
      end
      if (rst_mid) begin
         #1;
         rst = 1; cpu_req = 0; dbg_req = 0; dbg_lock = 0;
         c_pend = 0; d_pend = 0;
         model_reset();
      end else begin
         if (m_force) begin
            m_force = 0; m_starve = 0;
         end else if (m_locked && dbg_lock) begin
            m_starve = cpu_req ? m_starve + 1 : 0;
            if (m_starve >= LIMIT) begin m_force = 1; m_starve = 0; end
         end else begin
            m_locked = pd && dbg_lock;
            m_starve = 0;
         end
         if (pc) m_last_dbg = 0;
         if (pd) m_last_dbg = 1;
      end
   endtask

   task automatic reset_check();
      @(negedge clk);
      chk("rst_ctl", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_we}, 0);
      chk("rst_port", {mem_addr, mem_din}, 0);
      chk("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
      rst = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; cpu_req = 0; dbg_req = 0; dbg_lock = 0;
      c_pend = 0; d_pend = 0;
      model_reset();
      reset_check();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout @cyc %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      do_reset();
      // lone CPU read of 0x0010
      c_pend = 1; c_we = 0; c_addr = 16'h0010; c_wd = 0;
      step(0, 0, 0, 1);
      repeat (2) step(0, 0, 0, 1);
      // tie round-robin from reset: CPU first
      do_reset();
      repeat (4) step(100, 100, 0, 1);
      repeat (3) step(0, 0, 0, 1);
      // debug full-word write, then read it back
      d_pend = 1; d_we = 4'hF; d_addr = 16'h0100; d_wd = 32'h1234_5678;
      step(0, 0, 0, 0);
      d_pend = 1; d_we = 4'h0; d_addr = 16'h0100; d_wd = 0;
      repeat (3) step(0, 0, 0, 1);
      // lock, then CPU starts waiting: forced CPU grant, then release
      do_reset();
      repeat (3) step(0, 100, 1, 1);
      repeat (24) step(100, 100, 1, 1);
      repeat (6) step(100, 100, 0, 1);
      repeat (4) step(0, 0, 0, 1);
      // reset right behind a debug read grant
      d_pend = 1; d_we = 0; d_addr = 16'h0040; d_wd = 0;
      step(0, 0, 0, 1, 1);
      reset_check();
      repeat (3) step(0, 0, 0, 1);
      // random traffic with random locking
      for (int i = 0; i < 3000; i++)
         step(60, 60, 2, 0);
      repeat (12) step(0, 0, 0, 1);
      chk("drain", 64'(cq.size() + dq.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares BRAM port B between the CPU load/store unit and the UART debug memory-access controller (loader/dumper).
- Selects one requester per cycle, drives the single BRAM port and routes read data back to its owner after the BRAM read latency.
- Supports a debug lock for back-to-back dump bursts, with a starvation guard so the CPU keeps making progress.

Parameters:
- ADDR_WIDTH, 16, byte address width of the BRAM port.
- DATA_WIDTH, 32, data word width; byte-enable width is DATA_WIDTH/8.
- RD_LATENCY, 1, BRAM read latency in cycles; legal values 1 or 2.
- STARVE_LIMIT, 8, maximum consecutive locked debug cycles with cpu_req pending before one forced CPU grant.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  DATA_WIDTH/8  CPU byte write enables; 0 means read.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_gnt  out  1  CPU access accepted this cycle (combinational).
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_WIDTH  CPU read data.
- dbg_req  in  1  debug access request.
- dbg_lock  in  1  debug requests exclusive ownership while high.
- dbg_we  in  DATA_WIDTH/8  debug byte write enables; 0 means read.
- dbg_addr  in  ADDR_WIDTH  debug address.
- dbg_wdata  in  DATA_WIDTH  debug write data.
- dbg_gnt  out  1  debug access accepted this cycle (combinational).
- dbg_rvalid  out  1  debug read data valid.
- dbg_rdata  out  DATA_WIDTH  debug read data.
- mem_addr  out  ADDR_WIDTH  BRAM port-B address.
- mem_we  out  DATA_WIDTH/8  BRAM port-B byte write enables.
- mem_din  out  DATA_WIDTH  BRAM port-B write data.
- mem_dout  in  DATA_WIDTH  BRAM port-B read data.

Behaviour:
- Request handshake:
  - A request is consumed in the cycle its gnt is high.
  - Requester holds req, addr, we and wdata stable until granted.
  - cpu_gnt and dbg_gnt are never both high.
- Memory port drive:
  - mem_* is driven combinationally from the granted requester.
  - With no grant: mem_we = 0; mem_addr and mem_din hold their last registered values.
- State machine:
  - States: IDLE, SHARED, LOCKED, FORCE_CPU.
  - IDLE, no requests: no grant.
  - IDLE or SHARED, single requester: that requester is granted.
  - IDLE or SHARED, both requesting: grant goes to the side that is not last_winner (round-robin). last_winner resets to DBG, so the CPU wins the first tie.
  - Debug grant with dbg_lock = 1: move to LOCKED.
  - LOCKED: only dbg is granted. starve_cnt increments on each cycle with cpu_req high and clears when cpu_req is low.
  - LOCKED, starve_cnt reaches STARVE_LIMIT: move to FORCE_CPU.
  - FORCE_CPU: cpu_gnt = 1 for exactly one cycle (if cpu_req still high), dbg_gnt = 0, starve_cnt cleared, then back to LOCKED.
  - LOCKED, dbg_lock sampled low: move to SHARED. Grants follow the unlocked rules in that same cycle.
  - dbg_req = 0 while locked does not release the lock; only dbg_lock = 0 does.
- Read return:
  - A tag shift register, RD_LATENCY deep, records {valid, owner} for each granted read (we == 0).
  - Owner's rvalid asserts exactly RD_LATENCY cycles after the grant cycle.
  - cpu_rdata and dbg_rdata both carry mem_dout; only rvalid qualifies the data.
  - Writes produce no rvalid.
  - Back-to-back reads give one rvalid per cycle, in grant order.
- Reset:
  - All gnt and rvalid = 0; rdata = 0; mem_we = 0; mem_addr = 0; mem_din = 0.
  - State IDLE, starve_cnt = 0, tag pipeline cleared.
  - Reads in flight when reset asserts are dropped; no rvalid for them after reset.
- Widths: starve_cnt is clog2(STARVE_LIMIT+1) bits and saturates; it never wraps.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, adds two outputs:
  - cpu_stall_cnt[31:0]: cycles with cpu_req & ~cpu_gnt.
  - dbg_grant_cnt[31:0]: debug grants.
  - Both reset to 0 and saturate at 0xFFFFFFFF.
- When undefined: these ports and counters do not exist and all other behaviour is identical.

Test Plan:
- CPU read of addr 0x0010 alone, mem returns 0xDEADBEEF -> cpu_gnt same cycle; cpu_rvalid = 1 with cpu_rdata 0xDEADBEEF one cycle later; dbg_rvalid stays 0.
- cpu_req and dbg_req both high for 4 cycles, both reads -> grant order CPU, DBG, CPU, DBG; rvalids follow with 1-cycle lag to the matching owners.
- Debug write we = 4'b1111, addr 0x0100, data 0x12345678 -> mem_we = 1111, mem_addr 0x0100, mem_din 0x12345678 in the grant cycle; no rvalid.
- dbg_lock high with continuous dbg reads and cpu_req high, STARVE_LIMIT = 8 -> 8 debug grants, then exactly one cpu_gnt, then debug grants resume.
- dbg_lock drops mid-burst -> next tie is decided round-robin; the CPU is granted within 2 cycles.
- rst asserted one cycle after a debug read grant -> no dbg_rvalid; all outputs 0 in the next cycle; state IDLE.
